// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT_RAM frame controller.
package fft_pkg;

  localparam int FFT_AW      = 10;
  localparam int FFT_DW      = 28;
  localparam int FFT_RAM_LAT = 2;
  localparam int FFT_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    FILL,
    DETECT,
    DONE
  } fft_state_t;

  typedef logic [FFT_AW-1:0] bin_t;

endpackage

// File: rtl/fft_rd_arb.sv
// fft_rd_arb: shares the single FFT_RAM read port between the host readback
// and freqdetect, and times host read data with a RAM_LAT-deep valid pipe.
// The host address is latched on acceptance so the RAM sees a stable address
// for the whole read even if the host or the frame state moves on.
module fft_rd_arb
  import fft_pkg::*;
#(
  parameter int AW      = FFT_AW,
  parameter int DW      = FFT_DW,
  parameter int RAM_LAT = FFT_RAM_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_owns,
  input  logic          det_owns,
  input  logic [AW-1:0] det_ramaddr,
  input  logic          avs_read,
  input  logic [AW-1:0] avs_address,
  input  logic [DW-1:0] ram_q,
  output logic [AW-1:0] ram_rdaddr,
  output logic          avs_waitrequest,
  output logic [31:0]   avs_readdata,
  output logic          avs_readdatavalid,
  output logic          host_busy
);

  logic [RAM_LAT-1:0] vld_q, vld_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               accept;

  // Acceptance, valid pipe advance, address hold and read-port mux
  always_comb begin
    host_busy         = |vld_q;
    avs_waitrequest   = !host_owns || host_busy;
    accept            = avs_read && !avs_waitrequest;
    vld_d             = (vld_q << 1) | RAM_LAT'(accept);
    addr_d            = accept ? avs_address : addr_q;
    avs_readdatavalid = vld_q[RAM_LAT-1];
    avs_readdata      = {{(32-DW){1'b0}}, ram_q};
    if (host_busy) begin
      ram_rdaddr = addr_q;
    end else if (det_owns) begin
      ram_rdaddr = det_ramaddr;
    end else begin
      ram_rdaddr = avs_address;
    end
  end

  // Valid pipe and latched host address; reset is active-low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/fft_ram_ctrl.sv
// fft_ram_ctrl: frame sequencer for FFT_RAM. Lets FFT core writes through
// only while filling, starts freqdetect once a frame is in, latches its
// result, raises irq on completion or error, and hands the RAM read port to
// freqdetect while it searches (host readback otherwise).
// Note: the 'reset' port is active-low.
module fft_ram_ctrl
  import fft_pkg::*;
#(
  parameter int AW      = FFT_AW,
  parameter int DW      = FFT_DW,
  parameter int RAM_LAT = FFT_RAM_LAT,
  parameter int TIMEOUT = FFT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fft_wren_in,
  output logic          fft_wren_out,
  input  logic          fft_frame_done,
  output logic          det_start,
  input  logic          det_done,
  input  logic [AW-1:0] det_ramaddr,
  input  logic [AW-1:0] det_maxbin,
  output logic [AW-1:0] ram_rdaddr,
  input  logic [DW-1:0] ram_q,
  input  logic          avs_read,
  input  logic [AW-1:0] avs_address,
  output logic          avs_waitrequest,
  output logic [31:0]   avs_readdata,
  output logic          avs_readdatavalid,
  output logic [AW-1:0] maxbin,
  output logic          irq,
  input  logic          irq_ack,
  output logic [15:0]   frame_cnt,
  output logic [1:0]    status
);

  localparam int CW = $clog2(TIMEOUT);

  fft_state_t    state_q, state_d;
  logic [CW-1:0] det_cnt_q, det_cnt_d;
  logic          det_started_q, det_started_d;
  logic [AW-1:0] maxbin_q, maxbin_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          irq_q, irq_d;
  logic [1:0]    status_q, status_d;

  logic in_fill, in_detect, host_busy;
  logic timeout_hit, done_set, timeout_set, overrun_set;

  assign in_fill     = (state_q == FILL);
  assign in_detect   = (state_q == DETECT);
  assign timeout_hit = in_detect && (det_cnt_q == CW'(TIMEOUT - 1));
  assign done_set    = in_detect && det_done;
  assign timeout_set = timeout_hit && !det_done;
  assign overrun_set = fft_frame_done && !in_fill;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a completed search beats a timeout landing on the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fft_frame_done) state_d = DETECT;
      DETECT: begin
        if (det_done) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = FILL;
        end
      end
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs: RAM writable only while filling; start waits for host data
  always_comb begin
    fft_wren_out = 1'b0;
    det_start    = 1'b0;
    if (in_fill) begin
      fft_wren_out = fft_wren_in;
    end
    if (in_detect && !det_started_q && !host_busy) begin
      det_start = 1'b1;
    end
  end

  // Search bookkeeping, result capture, irq/status with set winning over ack
  always_comb begin
    det_cnt_d     = in_detect ? det_cnt_q + 1'b1 : '0;
    det_started_d = in_detect && (det_started_q || det_start);
    maxbin_d      = maxbin_q;
    frame_cnt_d   = frame_cnt_q;
    if (done_set) begin
      maxbin_d    = det_maxbin;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    status_d = irq_ack ? 2'b00 : status_q;
    if (timeout_set) status_d[1] = 1'b1;
    if (overrun_set) status_d[0] = 1'b1;
    irq_d = irq_ack ? 1'b0 : irq_q;
    if (done_set || timeout_set || overrun_set) irq_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_cnt_q     <= '0;
      det_started_q <= 1'b0;
      maxbin_q      <= '0;
      frame_cnt_q   <= '0;
      irq_q         <= 1'b0;
      status_q      <= '0;
    end else begin
      det_cnt_q     <= det_cnt_d;
      det_started_q <= det_started_d;
      maxbin_q      <= maxbin_d;
      frame_cnt_q   <= frame_cnt_d;
      irq_q         <= irq_d;
      status_q      <= status_d;
    end
  end

  assign maxbin    = maxbin_q;
  assign frame_cnt = frame_cnt_q;
  assign irq       = irq_q;
  assign status    = status_q;

  fft_rd_arb #(
    .AW      (AW),
    .DW      (DW),
    .RAM_LAT (RAM_LAT)
  ) u_rd_arb (
    .clk               (clk),
    .reset             (reset),
    .host_owns         (in_fill),
    .det_owns          (in_detect),
    .det_ramaddr       (det_ramaddr),
    .avs_read          (avs_read),
    .avs_address       (avs_address),
    .ram_q             (ram_q),
    .ram_rdaddr        (ram_rdaddr),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .host_busy         (host_busy)
  );

endmodule

// File: tb/tb_fft_ram_ctrl.sv
// tb_fft_ram_ctrl: drives fft_ram_ctrl with an FFT_RAM model, a scanning
// freqdetect model and a host, and checks against a frame-level reference.
module tb_fft_ram_ctrl;
  import fft_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              fft_wren_in, fft_wren_out, fft_frame_done;
  logic              det_start, det_done;
  bin_t              det_ramaddr, det_maxbin, ram_rdaddr, avs_address, maxbin;
  logic [FFT_DW-1:0] ram_q;
  logic              avs_read, avs_waitrequest, avs_readdatavalid;
  logic [31:0]       avs_readdata;
  logic              irq, irq_ack;
  logic [15:0]       frame_cnt;
  logic [1:0]        status;

  bin_t              ramWrAddr;
  logic [FFT_DW-1:0] ramWrData;
  logic [FFT_DW-1:0] ramMem [0:1023];
  logic [FFT_DW-1:0] ramStage;
  logic [FFT_DW-1:0] refMem [0:1023];

  int totalChecks   = 0;
  int badChecks     = 0;
  int detStartCount = 0;
  int expFrames     = 0;
  int expMaxbin     = 0;
  bit detMute       = 1'b0;

  always #5 clk = ~clk;

  fft_ram_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .fft_wren_in       (fft_wren_in),
    .fft_wren_out      (fft_wren_out),
    .fft_frame_done    (fft_frame_done),
    .det_start         (det_start),
    .det_done          (det_done),
    .det_ramaddr       (det_ramaddr),
    .det_maxbin        (det_maxbin),
    .ram_rdaddr        (ram_rdaddr),
    .ram_q             (ram_q),
    .avs_read          (avs_read),
    .avs_address       (avs_address),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .maxbin            (maxbin),
    .irq               (irq),
    .irq_ack           (irq_ack),
    .frame_cnt         (frame_cnt),
    .status            (status)
  );

  // FFT_RAM: write port straight from the FFT core, two-cycle read
  always @(posedge clk) begin
    if (fft_wren_out) ramMem[ramWrAddr] <= ramWrData;
    ramStage <= ramMem[ram_rdaddr];
    ram_q    <= ramStage;
  end

  // Count every det_start pulse seen
  always @(negedge clk) begin
    if (det_start) detStartCount++;
  end

  function automatic int magOf(input logic [FFT_DW-1:0] w);
    int re, im;
    re = int'($signed(w[27:14]));
    im = int'($signed(w[13:0]));
    return re * re + im * im;
  endfunction

  // Reference peak: first bin of largest magnitude in the written frame
  function automatic int refArgmax();
    int best;
    best = 0;
    for (int i = 1; i < 1024; i++) begin
      if (magOf(refMem[i]) > magOf(refMem[best])) best = i;
    end
    return best;
  endfunction

  // freqdetect model: scans all bins through the shared read port
  initial begin
    int best, bestMag, m;
    det_done    = 1'b0;
    det_ramaddr = '0;
    det_maxbin  = '0;
    forever begin
      @(negedge clk);
      if (det_start && !detMute) begin
        best    = 0;
        bestMag = -1;
        for (int k = 0; k <= 1024; k++) begin
          det_ramaddr = (k < 1024) ? bin_t'(k) : '0;
          @(negedge clk);
          if (k >= 1) begin
            m = magOf(ram_q);
            if (m > bestMag) begin
              bestMag = m;
              best    = k - 1;
            end
          end
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
        det_done   = 1'b1;
        det_maxbin = bin_t'(best);
        @(negedge clk);
        det_done   = 1'b0;
        det_maxbin = '0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write one full frame: kind 0 is the fixed peak-at-0xCC pattern, else random
  task automatic applyStimulus(input int kind);
    int probe;
    logic [FFT_DW-1:0] w;
    probe = $urandom_range(0, 1023);
    for (int i = 0; i < 1024; i++) begin
      if (kind == 0) w = (i == 204) ? 28'h0EE00EE : 28'h0AA00AA;
      else           w = FFT_DW'($urandom);
      ramWrAddr   = bin_t'(i);
      ramWrData   = w;
      fft_wren_in = 1'b1;
      refMem[i]   = w;
      if (i == probe) begin
        #1;
        checkOutput("wren_pass_fill", fft_wren_out, 1'b1);
      end
      @(negedge clk);
    end
    fft_wren_in = 1'b0;
  endtask

  task automatic pulseFrameDone();
    fft_frame_done = 1'b1;
    @(negedge clk);
    fft_frame_done = 1'b0;
  endtask

  task automatic waitFill(input string tag, input int budget, output int n);
    n = 0;
    while (avs_waitrequest && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, avs_waitrequest, 1'b0);
  endtask

  task automatic hostRead(input int addr, input int budget, output logic [31:0] data,
                          output int lat, output int waited);
    avs_address = bin_t'(addr);
    avs_read    = 1'b1;
    waited      = 0;
    #1;
    while (avs_waitrequest && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rd_accept", avs_waitrequest, 1'b0);
    lat  = 0;
    data = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) avs_read = 1'b0;
      if (avs_readdatavalid && lat == 0) begin
        lat  = k;
        data = avs_readdata;
      end
    end
  endtask

  task automatic ackIrq();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    #1;
    checkOutput("ack_irq", irq, 1'b0);
    checkOutput("ack_status", status, 2'b00);
  endtask

  task automatic checkFrame(input int snap, input logic [1:0] expStatus);
    checkOutput("frame_maxbin", maxbin, expMaxbin);
    checkOutput("frame_cnt", frame_cnt, expFrames);
    checkOutput("frame_irq", irq, 1'b1);
    checkOutput("frame_status", status, expStatus);
    checkOutput("frame_one_start", detStartCount - snap, 1);
  endtask

  initial begin
    logic [31:0] rdData;
    logic [1:0]  expStatus;
    int lat, waited, n, snap, a, r;

    reset          = 1'b0;
    fft_wren_in    = 1'b0;
    fft_frame_done = 1'b0;
    avs_read       = 1'b0;
    avs_address    = '0;
    irq_ack        = 1'b0;
    ramWrAddr      = '0;
    ramWrData      = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_irq", irq, 1'b0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_maxbin", maxbin, 0);
    checkOutput("rst_status", status, 2'b00);
    checkOutput("rst_det_start", det_start, 1'b0);
    checkOutput("rst_waitreq", avs_waitrequest, 1'b0);
    checkOutput("rst_rdvalid", avs_readdatavalid, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Known frame with its peak at bin 0xCC
    $display("[TB] fixed-pattern frame");
    applyStimulus(0);
    snap = detStartCount;
    pulseFrameDone();
    waitFill("t2_fill", 3000, n);
    expFrames = 1;
    expMaxbin = refArgmax();
    checkOutput("t2_maxbin_204", maxbin, 204);
    checkFrame(snap, 2'b00);
    ackIrq();

    // Host readback in FILL
    hostRead(204, 20, rdData, lat, waited);
    checkOutput("t5_data_cc", rdData, 32'h00EE00EE);
    checkOutput("t5_latency", lat, 2);
    hostRead(16, 20, rdData, lat, waited);
    checkOutput("t5_data_other", rdData, 32'h00AA00AA);

    // Reset in the middle of a search
    $display("[TB] reset mid-search");
    pulseFrameDone();
    repeat (20) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t1_irq", irq, 1'b0);
    checkOutput("t1_frame_cnt", frame_cnt, 0);
    checkOutput("t1_maxbin", maxbin, 0);
    checkOutput("t1_waitreq", avs_waitrequest, 1'b0);
    reset = 1'b1;
    snap  = detStartCount;
    repeat (1200) @(negedge clk);
    checkOutput("t1_no_restart", detStartCount - snap, 0);
    checkOutput("t1_stray_done_cnt", frame_cnt, 0);
    checkOutput("t1_stray_done_irq", irq, 1'b0);
    expFrames = 0;
    expMaxbin = 0;

    // Random frames with host traffic, wren in DETECT, and an overrun
    for (int it = 0; it < 3; it++) begin
      $display("[TB] random frame %0d", it);
      applyStimulus(1);
      expStatus = 2'b00;
      snap      = detStartCount;
      a         = $urandom_range(0, 1023);
      r         = $urandom_range(0, 1023);
      if (it == 1) begin
        avs_address    = bin_t'(r);
        avs_read       = 1'b1;
        fft_frame_done = 1'b1;
        #1;
        checkOutput("hold_accept", avs_waitrequest, 1'b0);
        @(negedge clk);
        avs_read       = 1'b0;
        fft_frame_done = 1'b0;
        avs_address    = bin_t'(r ^ 'h155);
        #1;
        checkOutput("hold_start_c1", det_start, 1'b0);
        checkOutput("hold_rdaddr", ram_rdaddr, r);
        @(negedge clk);
        checkOutput("hold_valid", avs_readdatavalid, 1'b1);
        checkOutput("hold_data", avs_readdata, {4'h0, refMem[r]});
        checkOutput("hold_start_c2", det_start, 1'b0);
        @(negedge clk);
        checkOutput("hold_start_c3", det_start, 1'b1);
      end else begin
        pulseFrameDone();
      end
      if (it == 0) begin
        ramWrAddr   = bin_t'(a);
        ramWrData   = ~refMem[a];
        fft_wren_in = 1'b1;
        #1;
        checkOutput("t6_wren_gated", fft_wren_out, 1'b0);
        @(negedge clk);
        fft_wren_in = 1'b0;
        hostRead(r, 5000, rdData, lat, waited);
        checkOutput("t5_stalled_in_detect", waited > 1000, 1'b1);
        checkOutput("t5_detect_read_data", rdData, {4'h0, refMem[r]});
        checkOutput("t5_detect_read_lat", lat, 2);
      end
      if (it == 2) begin
        repeat (5) @(negedge clk);
        pulseFrameDone();
        expStatus = 2'b01;
      end
      waitFill("frame_fill", 3000, n);
      if (it == 2) begin
        repeat (10) @(negedge clk);
        checkOutput("t4_no_restart", avs_waitrequest, 1'b0);
      end
      expFrames++;
      expMaxbin = refArgmax();
      checkFrame(snap, expStatus);
      if (it == 0) begin
        hostRead(a, 20, rdData, lat, waited);
        checkOutput("t6_ram_unchanged", rdData, {4'h0, refMem[a]});
      end
      ackIrq();
    end

    // Search timeout: freqdetect never answers
    $display("[TB] timeout");
    detMute = 1'b1;
    snap    = detStartCount;
    fft_frame_done = 1'b1;
    @(negedge clk);
    fft_frame_done = 1'b0;
    n = 1;
    while (avs_waitrequest && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t3_detect_cycles", n, 4097);
    checkOutput("t3_status", status, 2'b10);
    checkOutput("t3_irq", irq, 1'b1);
    checkOutput("t3_maxbin_kept", maxbin, expMaxbin);
    checkOutput("t3_frame_cnt_kept", frame_cnt, expFrames);
    checkOutput("t3_one_start", detStartCount - snap, 1);
    ackIrq();
    detMute = 1'b0;

    // Random readbacks of the last frame
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 1023);
      hostRead(r, 20, rdData, lat, waited);
      checkOutput("final_readback", rdData, {4'h0, refMem[r]});
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
